// File: rtl/button_reader.sv
// rtl/button_reader.sv - debounced pushbutton reader with press/release/long-hold strobes
//
// Ports:
//   clk           in   1  single clock for all logic
//   reset_n       in   1  asynchronous active-low reset
//   btn_raw       in   1  raw, possibly bouncing pushbutton pin (asynchronous)
//   btn_level     out  1  debounced pressed level, 1 = pressed
//   press_pulse   out  1  one-cycle strobe on each accepted press
//   release_pulse out  1  one-cycle strobe on each accepted release
//   long_pulse    out  1  one-cycle strobe, at most once per press, when the hold time is reached
//   press_count   out  8  running count of accepted presses, wraps at 256
module button_reader #(
  parameter int DEBOUNCE_CYCLES = 240000,
  parameter int LONG_CYCLES     = 12000000,
  parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       btn_raw,
  output logic       btn_level,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       long_pulse,
  output logic [7:0] press_count
);

  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int HW = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);
  // Pin level when the button is not pressed; synchronizer resets here so
  // leaving reset never looks like a press edge.
  localparam logic IDLE_PIN = BTN_ACTIVE_LOW;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    DEB_PRESS   = 2'd1,
    PRESSED     = 2'd2,
    DEB_RELEASE = 2'd3
  } state_t;

  state_t          state, state_d;
  logic            sync1, sync2;
  logic            act;
  logic [DW-1:0]   deb_t, deb_t_d;
  logic [HW-1:0]   hold_t, hold_t_d;
  logic            long_done, long_done_d;
  logic            btn_level_d, press_d, release_d, long_d;
  logic [7:0]      press_count_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= IDLE_PIN;
      sync2 <= IDLE_PIN;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  // Polarity-normalized synchronized level: 1 = pressed.
  assign act = sync2 ^ IDLE_PIN;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      deb_t         <= '0;
      hold_t        <= '0;
      long_done     <= 1'b0;
      btn_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      press_count   <= 8'd0;
    end else begin
      state         <= state_d;
      deb_t         <= deb_t_d;
      hold_t        <= hold_t_d;
      long_done     <= long_done_d;
      btn_level     <= btn_level_d;
      press_pulse   <= press_d;
      release_pulse <= release_d;
      long_pulse    <= long_d;
      press_count   <= press_count_d;
    end
  end

  always_comb begin
    state_d       = state;
    deb_t_d       = deb_t;
    hold_t_d      = hold_t;
    long_done_d   = long_done;
    btn_level_d   = btn_level;
    press_d       = 1'b0;
    release_d     = 1'b0;
    long_d        = 1'b0;
    press_count_d = press_count;

    // Hold timing runs through release debounce too, so a bouncy release
    // neither restarts the hold nor re-arms the long strobe.
    if (state == PRESSED || state == DEB_RELEASE) begin
      if (hold_t != HOLD_LAST) begin
        hold_t_d = hold_t + HW'(1);
      end else if (!long_done) begin
        long_d      = 1'b1;
        long_done_d = 1'b1;
      end
    end

    case (state)
      IDLE: begin
        if (act) begin
          state_d = DEB_PRESS;
          deb_t_d = '0;
        end
      end
      DEB_PRESS: begin
        if (!act) begin
          state_d = IDLE;
        end else if (deb_t == DEB_LAST) begin
          state_d       = PRESSED;
          press_d       = 1'b1;
          btn_level_d   = 1'b1;
          press_count_d = press_count + 8'd1;
          hold_t_d      = '0;
          long_done_d   = 1'b0;
        end else begin
          deb_t_d = deb_t + DW'(1);
        end
      end
      PRESSED: begin
        if (!act) begin
          state_d = DEB_RELEASE;
          deb_t_d = '0;
        end
      end
      DEB_RELEASE: begin
        if (act) begin
          state_d = PRESSED;
        end else if (deb_t == DEB_LAST) begin
          state_d     = IDLE;
          release_d   = 1'b1;
          btn_level_d = 1'b0;
        end else begin
          deb_t_d = deb_t + DW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_button_reader.sv
// tb/tb_button_reader.sv - randomized and directed bench for button_reader against a run-length reference model
module tb_button_reader;

  localparam int D = 4;
  localparam int L = 10;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       btn_raw;
  logic       btn_level, press_pulse, release_pulse, long_pulse;
  logic [7:0] press_count;

  button_reader #(
    .DEBOUNCE_CYCLES(D),
    .LONG_CYCLES(L),
    .BTN_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .btn_raw(btn_raw),
    .btn_level(btn_level),
    .press_pulse(press_pulse),
    .release_pulse(release_pulse),
    .long_pulse(long_pulse),
    .press_count(press_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: the pin reaches the debouncer two edges late; a level
  // change is accepted once the opposite level has been seen on D+1
  // consecutive edges; long fires on the L-th edge after acceptance of a
  // press if the button is still considered pressed at that edge.
  logic pin_q[$];
  int   m_run, m_since;
  bit   m_level;
  int   m_count;
  bit   e_press, e_rel, e_long;

  function automatic void model_reset();
    pin_q = '{1'b1, 1'b1};
    m_run = 0; m_since = 0; m_level = 0; m_count = 0;
    e_press = 0; e_rel = 0; e_long = 0;
  endfunction

  function automatic void model_edge(input logic raw);
    bit a;
    a = (pin_q.pop_front() == 1'b0);
    pin_q.push_back(raw);
    e_press = 0; e_rel = 0; e_long = 0;
    if (m_level) begin
      m_since++;
      if (m_since == L) e_long = 1;
      m_run = a ? 0 : m_run + 1;
      if (m_run == D + 1) begin
        m_level = 0; e_rel = 1; m_run = 0;
      end
    end else begin
      m_run = a ? m_run + 1 : 0;
      if (m_run == D + 1) begin
        m_level = 1; e_press = 1; m_run = 0; m_since = 0;
        m_count = (m_count + 1) % 256;
      end
    end
  endfunction

  // Per-segment observation of DUT strobes (index of first sighting, counts).
  int f_press, f_rel, f_long, c_press, c_rel, c_long;

  task automatic step(input logic raw, input int idx);
    @(negedge clk);
    btn_raw = raw;
    @(posedge clk);
    if (!reset_n) model_reset();
    else model_edge(raw);
    #1;
    check("btn_level", btn_level, m_level);
    check("press_pulse", press_pulse, e_press);
    check("release_pulse", release_pulse, e_rel);
    check("long_pulse", long_pulse, e_long);
    check("press_count", press_count, m_count);
    if (press_pulse) begin c_press++; if (f_press < 0) f_press = idx; end
    if (release_pulse) begin c_rel++; if (f_rel < 0) f_rel = idx; end
    if (long_pulse) begin c_long++; if (f_long < 0) f_long = idx; end
  endtask

  task automatic seg_clear();
    f_press = -1; f_rel = -1; f_long = -1;
    c_press = 0; c_rel = 0; c_long = 0;
  endtask

  task automatic hold(input logic raw, input int n);
    for (int i = 0; i < n; i++) step(raw, i);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_level"}, btn_level, 0);
    check({tag, "_press"}, press_pulse, 0);
    check({tag, "_release"}, release_pulse, 0);
    check({tag, "_long"}, long_pulse, 0);
    check({tag, "_count"}, press_count, 0);
  endtask

  // Called just after an edge; reset rises 2 ns later, before the next edge.
  task automatic apply_reset(input string tag, input int cycles);
    reset_n = 1'b0;
    #1;
    check_zero(tag);
    model_reset();
    hold(btn_raw, cycles);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    btn_raw = 1'b1;
    reset_n = 1'b0;
    model_reset();
    #3;
    check_zero("por");
    hold(1'b1, 3);
    #1;
    reset_n = 1'b1;

    // Bounce shorter than the debounce window is ignored.
    seg_clear();
    hold(1'b0, 3); hold(1'b1, 1); hold(1'b0, 3); hold(1'b1, 10);
    check("bounce_presses", c_press, 0);
    check("bounce_count", press_count, 0);
    check("bounce_level", btn_level, 0);

    // Clean press held 30 cycles: latency, single long strobe.
    seg_clear();
    hold(1'b0, 30);
    check("press_latency", f_press, 6);
    check("long_after_press", f_long - f_press, 10);
    check("long_once", c_long, 1);
    check("press_level", btn_level, 1);
    check("press_count_1", press_count, 1);

    // Release bounce while pressed: nothing happens.
    seg_clear();
    hold(1'b1, 2); hold(1'b0, 12);
    check("relbounce_release", c_rel, 0);
    check("relbounce_level", btn_level, 1);
    check("relbounce_long", c_long, 0);

    // Clean release.
    seg_clear();
    hold(1'b1, 20);
    check("release_latency", f_rel, 6);
    check("release_once", c_rel, 1);
    check("release_level", btn_level, 0);

    // Reset during PRESSED with the button still held.
    seg_clear();
    hold(1'b0, 12);
    check("pre_reset_level", btn_level, 1);
    apply_reset("midpress", 2);
    seg_clear();
    hold(1'b0, 15);
    check("post_reset_latency", f_press, 6);
    check("post_reset_count", press_count, 1);
    hold(1'b1, 15);

    // 256 clean presses wrap the counter.
    apply_reset("prewrap", 2);
    seg_clear();
    for (int k = 0; k < 256; k++) begin
      for (int i = 0; i < 8; i++) step(1'b0, i);
      for (int i = 0; i < 8; i++) step(1'b1, i);
    end
    check("wrap_pulses", c_press, 256);
    check("wrap_count", press_count, 0);

    // Random bouncy activity, including long holds.
    for (int s = 0; s < 300; s++) begin
      logic r;
      int n;
      r = 1'(($urandom_range(0, 1)));
      n = ($urandom_range(0, 7) == 0) ? $urandom_range(10, 25) : $urandom_range(1, 7);
      hold(r, n);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
